// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and the
// sequencing-controller state encoding.
package rv_pipe_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 6;
   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/rv_src_use_decode.sv
// Opcode-only decode of which source register fields an instruction reads.
module rv_src_use_decode
   import rv_pipe_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       rs1_used,
   output logic       rs2_used
);

   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (opcode)
         OP_R, OP_STORE, OP_BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: rs1_used = 1'b1;
         OP_LUI, OP_AUIPC, OP_JAL: begin
            rs1_used = 1'b0;
            rs2_used = 1'b0;
         end
         default: begin
            rs1_used = 1'b0;
            rs2_used = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush/freeze sequencing for load-use, taken-branch and
// multi-cycle data-memory hazards, with saturating perf counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; a memory access not ready this cycle freezes
//   MEM_WAIT | access outstanding; frozen until dmem_ready, timer running
module hazard_stall_controller
   import rv_pipe_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64,
   parameter int TMR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction_IFID,
   input  logic [31:0]      instruction_IDEX,
   input  logic             ID_EX_MemRead,
   input  logic             branch_taken_EX,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IDEX_write,
   output logic             EXMEM_write,
   output logic             IDEX_bubble,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             MEMWB_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout_err
);

   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ctrl_state_t      state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             err_q, err_d;

   logic [4:0] rd_idex, rs1_ifid, rs2_ifid;
   logic       rs1_used, rs2_used;
   logic       load_use, freeze;
   logic       unused_bits;

   assign rd_idex  = instruction_IDEX[RD_MSB:RD_LSB];
   assign rs1_ifid = instruction_IFID[RS1_MSB:RS1_LSB];
   assign rs2_ifid = instruction_IFID[RS2_MSB:RS2_LSB];
   assign unused_bits = ^{instruction_IDEX[31:12], instruction_IDEX[6:0],
                          instruction_IFID[31:25], instruction_IFID[14:7]};

   rv_src_use_decode u_src_use (
      .opcode   (instruction_IFID[OPC_MSB:OPC_LSB]),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used)
   );

   assign load_use = ID_EX_MemRead && (rd_idex != 5'd0) &&
                     ((rs1_used && (rd_idex == rs1_ifid)) ||
                      (rs2_used && (rd_idex == rs2_ifid)));

   assign freeze = ((state_q == RUN) && dmem_req && !dmem_ready) ||
                   ((state_q == MEM_WAIT) && !dmem_ready);

   // Freeze outranks the branch: the taken branch stays parked in EX and
   // is serviced in the release cycle.
   always_comb begin
      PC_write     = 1'b1;
      IFID_write   = 1'b1;
      IDEX_write   = 1'b1;
      EXMEM_write  = 1'b1;
      IDEX_bubble  = 1'b0;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      MEMWB_bubble = 1'b0;
      if (freeze) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         MEMWB_bubble = 1'b1;
      end else if (branch_taken_EX) begin
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
      end else if (load_use) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      err_d   = err_q;
      case (state_q)
         RUN: begin
            tmr_d = '0;
            if (dmem_req && !dmem_ready) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
               tmr_d   = '0;
            end else begin
               if (tmr_q != TMR_MAX) tmr_d = tmr_q + TMR_W'(1);
               if (tmr_d == TMR_MAX) err_d = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            tmr_d   = '0;
         end
      endcase

      stall_d = stall_q;
      if (!PC_write && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
      flush_d = flush_q;
      if (IFID_flush && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         tmr_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign stall_cycles    = stall_q;
   assign flush_count     = flush_q;
   assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller (small counters/timeout).
module tb_hazard_stall_controller;
   import rv_pipe_pkg::*;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      instruction_IFID, instruction_IDEX;
   logic             ID_EX_MemRead, branch_taken_EX, dmem_req, dmem_ready;
   logic             PC_write, IFID_write, IDEX_write, EXMEM_write;
   logic             IDEX_bubble, IFID_flush, IDEX_flush, MEMWB_bubble;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic             mem_timeout_err;
   logic [7:0]       outs;

   int nvec = 0;
   int nmis = 0;

   // {PC, IFID, IDEX, EXMEM, IDEX_bubble, IFID_flush, IDEX_flush, MEMWB_bubble}
   localparam logic [7:0] O_NORM   = 8'b1111_0000;
   localparam logic [7:0] O_FREEZE = 8'b0000_0001;
   localparam logic [7:0] O_BRANCH = 8'b1111_0110;
   localparam logic [7:0] O_LU     = 8'b0011_1000;

   localparam logic [31:0] LW_X5     = {12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD};
   localparam logic [31:0] LW_X0     = {12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD};
   localparam logic [31:0] ADD_6_1_5 = {7'd0, 5'd5, 5'd1, 3'b000, 5'd6, OP_R};
   localparam logic [31:0] ADD_1_0_0 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd1, OP_R};
   localparam logic [31:0] ADDI_6_1  = {12'd5, 5'd1, 3'b000, 5'd6, OP_IMM};
   localparam logic [31:0] ADDI_6_5  = {12'd0, 5'd5, 3'b000, 5'd6, OP_IMM};
   localparam logic [31:0] SW_5_1    = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, OP_STORE};
   localparam logic [31:0] LUI_7     = {7'd0, 5'd5, 5'd5, 3'b000, 5'd7, OP_LUI};

   assign outs = {PC_write, IFID_write, IDEX_write, EXMEM_write,
                  IDEX_bubble, IFID_flush, IDEX_flush, MEMWB_bubble};

   hazard_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TMR_W(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .instruction_IFID (instruction_IFID),
      .instruction_IDEX (instruction_IDEX),
      .ID_EX_MemRead    (ID_EX_MemRead),
      .branch_taken_EX  (branch_taken_EX),
      .dmem_req         (dmem_req),
      .dmem_ready       (dmem_ready),
      .PC_write         (PC_write),
      .IFID_write       (IFID_write),
      .IDEX_write       (IDEX_write),
      .EXMEM_write      (EXMEM_write),
      .IDEX_bubble      (IDEX_bubble),
      .IFID_flush       (IFID_flush),
      .IDEX_flush       (IDEX_flush),
      .MEMWB_bubble     (MEMWB_bubble),
      .stall_cycles     (stall_cycles),
      .flush_count      (flush_count),
      .mem_timeout_err  (mem_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      instruction_IFID = 32'h0000_0013;
      instruction_IDEX = 32'h0000_0013;
      ID_EX_MemRead    = 1'b0;
      branch_taken_EX  = 1'b0;
      dmem_req         = 1'b0;
      dmem_ready       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic set_lu(input logic [31:0] idex, input logic [31:0] ifid, input logic rd_flag);
      instruction_IDEX = idex;
      instruction_IFID = ifid;
      ID_EX_MemRead    = rd_flag;
      #1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      #3;
      check_val("reset_outs", 32'(outs), 32'(O_NORM));
      check_val("reset_stall", 32'(stall_cycles), 32'd0);
      check_val("reset_flush", 32'(flush_count), 32'd0);
      check_val("reset_err", 32'(mem_timeout_err), 32'd0);
      tick();
      reset = 1'b0;
      #1;

      // load-use on rs2, one bubble then the consumer proceeds
      set_lu(LW_X5, ADD_6_1_5, 1'b1);
      check_val("lu_rs2", 32'(outs), 32'(O_LU));
      tick();
      set_lu(32'h0000_0013, ADD_6_1_5, 1'b0);
      check_val("lu_after", 32'(outs), 32'(O_NORM));
      check_val("lu_stall_cnt", 32'(stall_cycles), 32'd1);

      set_lu(LW_X0, ADD_1_0_0, 1'b1);
      check_val("lu_rd_x0", 32'(outs), 32'(O_NORM));
      set_lu(LW_X5, ADDI_6_1, 1'b1);
      check_val("lu_imm_not_rs2", 32'(outs), 32'(O_NORM));
      set_lu(LW_X5, ADDI_6_5, 1'b1);
      check_val("lu_rs1", 32'(outs), 32'(O_LU));
      set_lu(LW_X5, SW_5_1, 1'b1);
      check_val("lu_store_rs2", 32'(outs), 32'(O_LU));
      set_lu(LW_X5, LUI_7, 1'b1);
      check_val("lu_lui", 32'(outs), 32'(O_NORM));
      set_lu(LW_X5, ADD_6_1_5, 1'b0);
      check_val("lu_not_load", 32'(outs), 32'(O_NORM));

      // taken branch outranks load-use
      do_reset();
      set_lu(LW_X5, ADD_6_1_5, 1'b1);
      branch_taken_EX = 1'b1;
      #1;
      check_val("br_over_lu", 32'(outs), 32'(O_BRANCH));
      tick();
      idle_inputs();
      #1;
      check_val("br_flush_cnt", 32'(flush_count), 32'd1);
      check_val("br_stall_cnt", 32'(stall_cycles), 32'd0);

      // memory wait with a pending branch held through the freeze
      do_reset();
      dmem_req = 1'b1;
      branch_taken_EX = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val($sformatf("mw_freeze%0d", i), 32'(outs), 32'(O_FREEZE));
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      check_val("mw_release", 32'(outs), 32'(O_BRANCH));
      tick();
      idle_inputs();
      #1;
      check_val("mw_back_run", 32'(outs), 32'(O_NORM));
      check_val("mw_stall_cnt", 32'(stall_cycles), 32'd3);
      check_val("mw_flush_cnt", 32'(flush_count), 32'd1);

      dmem_req = 1'b1;
      dmem_ready = 1'b1;
      #1;
      check_val("mw_ready_same", 32'(outs), 32'(O_NORM));
      tick();
      idle_inputs();
      #1;
      check_val("mw_ready_run", 32'(outs), 32'(O_NORM));

      // timeout after the fourth MEM_WAIT cycle, sticky afterwards
      do_reset();
      dmem_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val($sformatf("to_err%0d", i), 32'(mem_timeout_err), (i >= 4) ? 32'd1 : 32'd0);
      end
      check_val("to_stall_sat", 32'(stall_cycles), 32'd3);
      dmem_ready = 1'b1;
      #1;
      check_val("to_release", 32'(outs), 32'(O_NORM));
      tick();
      idle_inputs();
      #1;
      check_val("to_sticky", 32'(mem_timeout_err), 32'd1);
      check_val("to_run", 32'(outs), 32'(O_NORM));

      // asynchronous reset in the middle of a wait
      dmem_req = 1'b1;
      branch_taken_EX = 1'b1;
      tick();
      tick();
      dmem_req = 1'b0;
      #1;
      check_val("rmw_frozen", 32'(outs), 32'(O_FREEZE));
      branch_taken_EX = 1'b0;
      reset = 1'b1;
      #1;
      check_val("rmw_outs", 32'(outs), 32'(O_NORM));
      check_val("rmw_stall", 32'(stall_cycles), 32'd0);
      check_val("rmw_flush", 32'(flush_count), 32'd0);
      check_val("rmw_err", 32'(mem_timeout_err), 32'd0);
      tick();
      reset = 1'b0;
      #1;

      // stall counter saturation at 2^CNT_W-1
      set_lu(LW_X5, ADD_6_1_5, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      idle_inputs();
      #1;
      check_val("sat_stall", 32'(stall_cycles), 32'd3);

      // flush counter saturation
      branch_taken_EX = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      idle_inputs();
      #1;
      check_val("sat_flush", 32'(flush_count), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
